// File: rtl/co224_pkg.sv
// -----------------------------------------------------------------------------
// co224_pkg
// Shared definitions for the CO224 8-bit processor with data cache:
//   - data-memory latency and field widths
//   - opcode constants
//   - data-cache FSM state type
//   - branch/jump offset helper (word offset -> byte offset, sign extended)
// No ports (package).
// -----------------------------------------------------------------------------
package co224_pkg;

  localparam int MEM_LATENCY = 5;  // data-memory cycles per block read or write
  localparam int NUM_REGS    = 8;
  localparam int NUM_BLOCKS  = 8;
  localparam int DATA_W      = 8;
  localparam int REG_AW      = 3;
  localparam int CNT_W       = 3;  // wide enough to count to MEM_LATENCY-1

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_LWD   = 8'h08;
  localparam logic [7:0] OP_LWI   = 8'h09;
  localparam logic [7:0] OP_SWD   = 8'h0A;
  localparam logic [7:0] OP_SWI   = 8'h0B;

  typedef enum logic [1:0] {
    C_IDLE,
    C_WRITEBACK,
    C_FETCH,
    C_UPDATE
  } cache_state_t;

  // Offsets are in words; shift to bytes after sign extension.
  function automatic logic [31:0] branch_offset(input logic [7:0] off);
    return {{22{off[7]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/cpu_cache_system_cpu.sv
// -----------------------------------------------------------------------------
// regfile   : 8 x 8-bit registers, two combinational read ports, one write.
// data_mem  : 256-byte data memory, block (4-byte) write and registered read.
// cpu       : single-cycle core; decode, ALU, PC, stalls on o_busywait.
// cpu ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_instruction    fetched instruction word
//   o_pc             byte address of the current instruction
// -----------------------------------------------------------------------------
module regfile
  import co224_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr1,
  input  logic [REG_AW-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);
  logic [DATA_W-1:0] reg_array [0:NUM_REGS-1];

  assign o_rdata1 = reg_array[i_raddr1];
  assign o_rdata2 = reg_array[i_raddr2];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) reg_array[i] <= '0;
    end else if (i_we) begin
      reg_array[i_waddr] <= i_wdata;
    end
  end
endmodule

module data_mem (
  input  logic        i_clk,
  input  logic        i_write,
  input  logic [5:0]  i_block,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  memory_array [0:255];
  logic [31:0] r_rdata;

  assign o_rdata = r_rdata;

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_write) memory_array[{i_block, b[1:0]}] <= i_wdata[b*8 +: 8];
      r_rdata[b*8 +: 8] <= memory_array[{i_block, b[1:0]}];
    end
  end
endmodule

module cpu
  import co224_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_pc
);
  logic [31:0]       r_pc, w_pc_plus4, w_target;
  logic [7:0]        w_op, w_off, w_imm, w_mem_addr;
  logic [REG_AW-1:0] w_rd, w_rs1, w_rs2;
  logic [DATA_W-1:0] w_a, w_b, w_result, w_cache_rdata;
  logic              w_reg_we, w_mem_read, w_mem_write, w_take, w_busywait;
  logic              w_mem_we;
  logic [5:0]        w_mem_block;
  logic [31:0]       w_mem_wdata, w_mem_rdata;
  logic              w_unused_src1_hi;

  assign w_op             = i_instruction[31:24];
  assign w_off            = i_instruction[23:16];
  assign w_rd             = i_instruction[18:16];
  assign w_rs1            = i_instruction[10:8];
  assign w_rs2            = i_instruction[2:0];
  assign w_imm            = i_instruction[7:0];
  assign w_unused_src1_hi = ^i_instruction[15:11];

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_target   = w_pc_plus4 + branch_offset(w_off);
  assign o_pc       = r_pc;

  always_comb begin
    w_result    = '0;
    w_reg_we    = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_mem_addr  = w_imm;
    w_take      = 1'b0;
    case (w_op)
      OP_LOADI: begin w_result = w_imm;       w_reg_we = 1'b1; end
      OP_MOV:   begin w_result = w_b;         w_reg_we = 1'b1; end
      OP_ADD:   begin w_result = w_a + w_b;   w_reg_we = 1'b1; end
      OP_SUB:   begin w_result = w_a - w_b;   w_reg_we = 1'b1; end
      OP_AND:   begin w_result = w_a & w_b;   w_reg_we = 1'b1; end
      OP_OR:    begin w_result = w_a | w_b;   w_reg_we = 1'b1; end
      OP_J:     w_take = 1'b1;
      OP_BEQ:   w_take = (w_a == w_b);
      OP_LWD:   begin w_mem_read = 1'b1; w_mem_addr = w_b; w_result = w_cache_rdata; w_reg_we = 1'b1; end
      OP_LWI:   begin w_mem_read = 1'b1; w_result = w_cache_rdata; w_reg_we = 1'b1; end
      OP_SWD:   begin w_mem_write = 1'b1; w_mem_addr = w_b; end
      OP_SWI:   w_mem_write = 1'b1;
      default:  ;
    endcase
  end

  // A miss freezes the whole core: no PC step and no register write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (!w_busywait) begin
      r_pc <= w_take ? w_target : w_pc_plus4;
    end
  end

  regfile u_regfile (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_reg_we && !w_busywait),
    .i_waddr  (w_rd),
    .i_wdata  (w_result),
    .i_raddr1 (w_rs1),
    .i_raddr2 (w_rs2),
    .o_rdata1 (w_a),
    .o_rdata2 (w_b)
  );

  data_cache u_data_cache (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_read      (w_mem_read),
    .i_write     (w_mem_write),
    .i_addr      (w_mem_addr),
    .i_wdata     (w_a),
    .o_rdata     (w_cache_rdata),
    .o_busywait  (w_busywait),
    .o_mem_write (w_mem_we),
    .o_mem_block (w_mem_block),
    .o_mem_wdata (w_mem_wdata),
    .i_mem_rdata (w_mem_rdata)
  );

  data_mem u_data_mem (
    .i_clk   (i_clk),
    .i_write (w_mem_we),
    .i_block (w_mem_block),
    .i_wdata (w_mem_wdata),
    .o_rdata (w_mem_rdata)
  );
endmodule

// File: rtl/cpu_cache_system_data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back, write-allocate cache: 8 blocks x 4 bytes.
// Address split: tag[7:5], index[4:2], offset[1:0].
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_read, i_write    CPU access request (combinational from decode)
//   i_addr, i_wdata    CPU byte address / store data
//   o_rdata            combinational read data (valid on hit)
//   o_busywait         high while a miss is being serviced
//   o_mem_write        one-cycle block write strobe to data memory
//   o_mem_block        block address (addr[7:2]) presented to data memory
//   o_mem_wdata        victim block being written back
//   i_mem_rdata        registered block read data from data memory
// -----------------------------------------------------------------------------
module data_cache
  import co224_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [DATA_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busywait,
  output logic              o_mem_write,
  output logic [5:0]        o_mem_block,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  logic [31:0]           data_blocks [0:NUM_BLOCKS-1];
  logic [2:0]            r_tag       [0:NUM_BLOCKS-1];
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;
  cache_state_t          r_state, w_state_next;
  logic [CNT_W-1:0]      r_cnt, w_cnt_next;

  logic [2:0]  w_tag, w_idx;
  logic [1:0]  w_off;
  logic        w_hit, w_wr_hit;
  logic [31:0] w_block_wr;

  assign w_tag    = i_addr[7:5];
  assign w_idx    = i_addr[4:2];
  assign w_off    = i_addr[1:0];
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_wr_hit = (r_state == C_IDLE) && i_write && w_hit;
  assign o_rdata  = data_blocks[w_idx][{w_off, 3'b000} +: 8];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_block_wr[gi*8 +: 8] = (w_off == 2'(gi)) ? i_wdata
                                                       : data_blocks[w_idx][gi*8 +: 8];
    end
  endgenerate

  // The cycle in which the miss is detected already counts as the first
  // memory cycle of the first transfer, hence r_cnt starts at 1 from IDLE.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    o_busywait   = 1'b0;
    o_mem_write  = 1'b0;
    o_mem_block  = {w_tag, w_idx};
    o_mem_wdata  = data_blocks[w_idx];
    case (r_state)
      C_IDLE: begin
        if ((i_read || i_write) && !w_hit) begin
          o_busywait   = 1'b1;
          w_cnt_next   = CNT_W'(1);
          w_state_next = (r_valid[w_idx] && r_dirty[w_idx]) ? C_WRITEBACK : C_FETCH;
        end
      end
      C_WRITEBACK: begin
        o_busywait  = 1'b1;
        o_mem_block = {r_tag[w_idx], w_idx};
        if (r_cnt == CNT_LAST) begin
          o_mem_write  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = C_FETCH;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      C_FETCH: begin
        o_busywait = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_next   = '0;
          w_state_next = C_UPDATE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      C_UPDATE: begin
        o_busywait   = 1'b1;
        w_state_next = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= C_IDLE;
      r_cnt   <= '0;
      r_valid <= '0;
      r_dirty <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == C_UPDATE) begin
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end else if (w_wr_hit) begin
        r_dirty[w_idx] <= 1'b1;
      end
    end
  end

  // Block data and tags carry no reset; they are qualified by r_valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == C_UPDATE) begin
        data_blocks[w_idx] <= i_mem_rdata;
        r_tag[w_idx]       <= w_tag;
      end else if (w_wr_hit) begin
        data_blocks[w_idx] <= w_block_wr;
      end
    end
  end

endmodule

// File: rtl/cpu_cache_system.sv
// -----------------------------------------------------------------------------
// cpu_cache_system
// Top of the CO224 8-bit single-cycle processor with data cache.
// Ports:
//   CLK          single clock, rising-edge state updates
//   RESET        synchronous, active-high
//   INSTRUCTION  fetched instruction word from external instruction memory
//   PC_OUT       byte address of the current instruction
// -----------------------------------------------------------------------------
module cpu_cache_system (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT
);
  cpu u_cpu (
    .i_clk         (CLK),
    .i_rst         (RESET),
    .i_instruction (INSTRUCTION),
    .o_pc          (PC_OUT)
  );
endmodule

// File: tb/tb_cpu_cache_system.sv
// -----------------------------------------------------------------------------
// tb_cpu_cache_system
// Runs a small directed program from a bench-side instruction memory.
// The stimulus process pushes the expected retirement trace (PC, stall
// cycles, register/memory effect); the monitor pops one entry each time the
// PC moves on and compares.
// -----------------------------------------------------------------------------
module tb_cpu_cache_system;
  import co224_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] INSTRUCTION;
  logic [31:0] PC_OUT;

  logic [31:0] imem [0:63];

  localparam int K_NONE = 0;
  localparam int K_REG  = 1;
  localparam int K_MEM  = 2;

  typedef struct {
    logic [31:0] pc;
    int          stall;
    int          kind;
    int          idx;
    logic [7:0]  val;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic        mon_en   = 1'b0;
  logic [31:0] mon_pc;
  int          mon_cnt;

  cpu_cache_system dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC_OUT      (PC_OUT)
  );

  always #5 CLK = ~CLK;

  assign #2 INSTRUCTION = imem[PC_OUT[7:2]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] pc, input int stall, input int kind,
                      input int idx, input logic [7:0] val);
    exp_t e;
    e.pc = pc; e.stall = stall; e.kind = kind; e.idx = idx; e.val = val;
    sb_q.push_back(e);
  endtask

  // Monitor: a PC change at a negedge means the instruction at mon_pc retired.
  always @(negedge CLK) begin
    if (mon_en) begin
      if (PC_OUT == mon_pc) begin
        mon_cnt++;
      end else begin
        if (sb_q.size() == 0) begin
          check("unexpected_retire", mon_pc, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("retire pc=%0d stall=%0d next_pc=%0d", mon_pc, mon_cnt - 1, PC_OUT);
          check("retire_pc", mon_pc, e.pc);
          check("stall_cycles", 32'(mon_cnt - 1), 32'(e.stall));
          if (e.kind == K_REG)
            check("reg_value", 32'(dut.u_cpu.u_regfile.reg_array[e.idx]), 32'(e.val));
          else if (e.kind == K_MEM)
            check("mem_value", 32'(dut.u_cpu.u_data_mem.memory_array[e.idx]), 32'(e.val));
        end
        mon_pc  = PC_OUT;
        mon_cnt = 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;  // NOP
    imem[0]  = 32'h0001_0005;  // 0  loadi r1,5
    imem[1]  = 32'h0002_0005;  // 4  loadi r2,5
    imem[2]  = 32'h0601_0000;  // 8  j +1      -> 16
    imem[3]  = 32'h0601_0000;  // 12 j +1      -> 20
    imem[4]  = 32'h07FE_0102;  // 16 beq r1,r2,-2 (taken) -> 12
    imem[5]  = 32'h0002_0003;  // 20 loadi r2,3
    imem[6]  = 32'h0303_0102;  // 24 sub r3,r1,r2 = 2
    imem[7]  = 32'h0204_0102;  // 28 add r4,r1,r2 = 8
    imem[8]  = 32'h07FE_0102;  // 32 beq r1,r2,-2 (not taken)
    imem[9]  = 32'h0B00_0104;  // 36 swi r1,0x04 (cold miss)
    imem[10] = 32'h0905_0004;  // 40 lwi r5,0x04 (hit)
    imem[11] = 32'h0B00_0124;  // 44 swi r1,0x24 (dirty victim)
    imem[12] = 32'h0406_0102;  // 48 and r6,r1,r2 = 1
    imem[13] = 32'h0507_0102;  // 52 or  r7,r1,r2 = 7
    imem[14] = 32'h0100_0004;  // 56 mov r0,r4 = 8
    imem[15] = 32'h0A00_0403;  // 60 swd M[r3]=r4 (clean miss, idx 0)
    imem[16] = 32'h0806_0003;  // 64 lwd r6,M[r3] = 8
    imem[17] = 32'h0907_0024;  // 68 lwi r7,0x24 = 5 (hit)
    imem[18] = 32'h0902_0004;  // 72 lwi r2,0x04 = 5 (dirty victim)
    imem[19] = 32'hFF00_0000;  // 76 nop
    imem[20] = 32'h06FE_0000;  // 80 j -2      -> 76

    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset_pc", PC_OUT, 32'd0);
    for (int r = 0; r < 8; r++)
      check("reset_reg", 32'(dut.u_cpu.u_regfile.reg_array[r]), 32'd0);
    check("reset_state", 32'(dut.u_cpu.u_data_cache.r_state), 32'(C_IDLE));
    check("reset_busy", 32'(dut.u_cpu.w_busywait), 32'd0);

    push(0,  0,  K_REG,  1, 8'd5);
    push(4,  0,  K_REG,  2, 8'd5);
    push(8,  0,  K_NONE, 0, 8'd0);
    push(16, 0,  K_NONE, 0, 8'd0);
    push(12, 0,  K_NONE, 0, 8'd0);
    push(20, 0,  K_REG,  2, 8'd3);
    push(24, 0,  K_REG,  3, 8'd2);
    push(28, 0,  K_REG,  4, 8'd8);
    push(32, 0,  K_NONE, 0, 8'd0);
    push(36, MEM_LATENCY + 1,     K_NONE, 0, 8'd0);
    push(40, 0,  K_REG,  5, 8'd5);
    push(44, 2 * MEM_LATENCY + 1, K_MEM,  4, 8'd5);
    push(48, 0,  K_REG,  6, 8'd1);
    push(52, 0,  K_REG,  7, 8'd7);
    push(56, 0,  K_REG,  0, 8'd8);
    push(60, MEM_LATENCY + 1,     K_NONE, 0, 8'd0);
    push(64, 0,  K_REG,  6, 8'd8);
    push(68, 0,  K_REG,  7, 8'd5);
    push(72, 2 * MEM_LATENCY + 1, K_REG,  2, 8'd5);
    push(76, 0,  K_NONE, 0, 8'd0);
    push(80, 0,  K_NONE, 0, 8'd0);
    push(76, 0,  K_NONE, 0, 8'd0);

    #1;
    mon_pc  = 32'd0;
    mon_cnt = 1;
    mon_en  = 1'b1;
    RESET   = 1'b0;

    for (int c = 0; c < 400 && sb_q.size() != 0; c++) begin
      @(negedge CLK);
      #1;
    end
    check("trace_drained", 32'(sb_q.size()), 32'd0);
    mon_en = 1'b0;

    // Reset in the middle of a miss.
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    #1;
    RESET = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (PC_OUT == 32'd36) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_miss", 32'(found), 32'd1);
    repeat (2) @(negedge CLK);
    check("mid_miss_state", 32'(dut.u_cpu.u_data_cache.r_state), 32'(C_FETCH));
    check("mid_miss_pc", PC_OUT, 32'd36);
    #1;
    RESET = 1'b1;
    @(negedge CLK);
    $display("reset during miss pc=%0d", PC_OUT);
    check("abort_state", 32'(dut.u_cpu.u_data_cache.r_state), 32'(C_IDLE));
    check("abort_busy", 32'(dut.u_cpu.w_busywait), 32'd0);
    check("abort_pc", PC_OUT, 32'd0);
    check("abort_reg1", 32'(dut.u_cpu.u_regfile.reg_array[1]), 32'd0);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    check("restart_pc", PC_OUT, 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
